// File: rtl/riscv_pkg.sv
// Shared MEM-stage definitions: funct3 load/store encodings, LSU FSM states
// and the access-size decode used by both the aligner and the control path.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    // Any funct3 outside the defined load set behaves as LW.
    function automatic acc_size_t load_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: return SZ_BYTE;
            F3_LH, F3_LHU: return SZ_HALF;
            default:       return SZ_WORD;
        endcase
    endfunction

    function automatic acc_size_t store_size(input logic [2:0] f3);
        case (f3)
            F3_SB:   return SZ_BYTE;
            F3_SH:   return SZ_HALF;
            F3_SW:   return SZ_WORD;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational byte-lane logic: store strobe/replication and misalign detect
// for the incoming request, load lane select and extension for returned data.
module lsu_data_align
    import riscv_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_addr_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        misalign,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    acc_size_t size;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        size     = is_store ? store_size(req_funct3) : load_size(req_funct3);
        misalign = 1'b0;
        wstrb    = '0;
        wdata    = '0;
        case (size)
            SZ_HALF: misalign = req_addr_lo[0];
            SZ_WORD: misalign = |req_addr_lo;
            default: misalign = 1'b0;
        endcase
        if (is_store) begin
            case (size)
                SZ_BYTE: begin
                    wstrb = 4'b0001 << req_addr_lo;
                    wdata = {4{st_data[7:0]}};
                end
                SZ_HALF: begin
                    wstrb = req_addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata = {2{st_data[15:0]}};
                end
                default: begin
                    wstrb = 4'b1111;
                    wdata = st_data;
                end
            endcase
        end
    end

    always_comb begin
        ld_byte = rdata[{ld_addr_lo, 3'b000} +: 8];
        ld_half = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (ld_funct3)
            F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_data = {24'b0, ld_byte};
            F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            F3_LHU:  ld_data = {16'b0, ld_half};
            F3_LW:   ld_data = rdata;
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: pass-through of ALU results, or one load/store over a req/ack bus
// with timeout, registered into a one-cycle WB pulse.
//   state   | meaning
//   ST_IDLE | accepting EX results; non-mem and misaligned ops retire next cycle
//   ST_WAIT | bus request outstanding; upstream stalled until ack or timeout
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] wr_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        exc_misalign,
    output logic        exc_bus_err
);

    lsu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      addr_q, wdata_q;
    logic [3:0]       wstrb_q;
    logic             we_q, rw_q;
    logic [2:0]       f3_q;
    logic [4:0]       rd_q;

    logic        mem_op, is_store, misalign, start, done, timeout, stall_c, last_cnt;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata, ld_data;

    assign mem_op   = mem_read | mem_write;
    assign is_store = mem_write & ~mem_read;
    assign start    = in_valid & mem_op & ~misalign;
    assign last_cnt = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    lsu_data_align u_align (
        .is_store    (is_store),
        .req_funct3  (funct3),
        .req_addr_lo (alu_result[1:0]),
        .st_data     (wr_data),
        .wstrb       (al_wstrb),
        .wdata       (al_wdata),
        .misalign    (misalign),
        .ld_funct3   (f3_q),
        .ld_addr_lo  (addr_q[1:0]),
        .rdata       (dmem_rdata),
        .ld_data     (ld_data)
    );

    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        done    = 1'b0;
        timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT;
                    stall_c = 1'b1;
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else if (last_cnt) begin
                    timeout = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset gates stall so it falls immediately even while a mem op is presented.
    assign stall      = stall_c & reset;
    assign dmem_req   = (state_q == ST_WAIT);
    assign dmem_we    = dmem_req & we_q;
    assign dmem_addr  = dmem_req ? {addr_q[31:2], 2'b00} : '0;
    assign dmem_wdata = dmem_req ? wdata_q : '0;
    assign dmem_wstrb = dmem_req ? wstrb_q : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            we_q         <= 1'b0;
            rw_q         <= 1'b0;
            f3_q         <= '0;
            rd_q         <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            exc_misalign <= 1'b0;
            exc_bus_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wb_valid     <= 1'b0;
            exc_misalign <= 1'b0;
            exc_bus_err  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && !mem_op) begin
                        wb_valid     <= 1'b1;
                        wb_data      <= alu_result;
                        wb_rd        <= rd_in;
                        wb_reg_write <= reg_write_in;
                    end else if (in_valid && misalign) begin
                        wb_valid     <= 1'b1;
                        exc_misalign <= 1'b1;
                        wb_data      <= alu_result;
                        wb_rd        <= rd_in;
                        wb_reg_write <= 1'b0;
                    end else if (start) begin
                        cnt_q   <= '0;
                        addr_q  <= alu_result;
                        wdata_q <= al_wdata;
                        wstrb_q <= al_wstrb;
                        we_q    <= is_store;
                        rw_q    <= reg_write_in & ~is_store;
                        f3_q    <= funct3;
                        rd_q    <= rd_in;
                    end
                end
                ST_WAIT: begin
                    if (done) begin
                        wb_valid     <= 1'b1;
                        wb_rd        <= rd_q;
                        wb_reg_write <= rw_q;
                        if (!we_q) wb_data <= ld_data;
                    end else if (timeout) begin
                        wb_valid     <= 1'b1;
                        exc_bus_err  <= 1'b1;
                        wb_rd        <= rd_q;
                        wb_reg_write <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed scenarios plus randomized ops against a
// byte-arithmetic reference model of the load/store lane rules.
module tb_mem_stage_lsu;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] alu_result = '0, wr_data = '0, dmem_rdata = '0;
    logic        mem_read = 1'b0, mem_write = 1'b0, reg_write_in = 1'b0, dmem_ack = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rd_in = '0;
    logic        stall, dmem_req, dmem_we, wb_valid, wb_reg_write, exc_misalign, exc_bus_err;
    logic [31:0] dmem_addr, dmem_wdata, wb_data;
    logic [3:0]  dmem_wstrb;
    logic [4:0]  wb_rd;

    int total = 0;
    int bad = 0;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .alu_result(alu_result),
        .wr_data(wr_data), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .rd_in(rd_in), .reg_write_in(reg_write_in), .stall(stall), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .exc_misalign(exc_misalign), .exc_bus_err(exc_bus_err)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    function automatic int sz_of(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        int sz;
        logic [31:0] v, mask;
        sz = sz_of(f3);
        if (sz == 4) return rdata;
        mask = (sz == 1) ? 32'hFF : 32'hFFFF;
        v = (rdata >> (8 * (addr % 4))) & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] m_wstrb(input int sz, input logic [31:0] addr);
        logic [3:0] m;
        m = 4'((1 << sz) - 1);
        return m << (addr % 4);
    endfunction

    function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] wd);
        if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    // ---------------- stimulus driver (observes, does not judge) ----------------
    int          obs_stall_cnt, obs_req_cnt;
    logic        obs_bus_changed, obs_hung, obs_req_after, obs_we;
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_wstrb;

    // Entered and left at posedge+1. Holds the op while stalled, acks after ack_delay WAIT cycles.
    task automatic run_op(input logic mr, input logic mw, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd, input logic rw,
                          input int ack_delay, input logic [31:0] rdata);
        in_valid = 1'b1; mem_read = mr; mem_write = mw; funct3 = f3; alu_result = addr;
        wr_data = wd; rd_in = rd; reg_write_in = rw;
        obs_stall_cnt = 0; obs_req_cnt = 0; obs_bus_changed = 1'b0; obs_hung = 1'b1;
        for (int c = 0; c < 40; c++) begin
            dmem_ack   = dmem_req && (obs_req_cnt == ack_delay);
            dmem_rdata = dmem_ack ? rdata : $urandom();
            if (dmem_req) begin
                if (obs_req_cnt == 0) begin
                    obs_addr = dmem_addr; obs_we = dmem_we; obs_wstrb = dmem_wstrb; obs_wdata = dmem_wdata;
                end else if ({obs_addr, obs_we, obs_wstrb, obs_wdata} !== {dmem_addr, dmem_we, dmem_wstrb, dmem_wdata}) begin
                    obs_bus_changed = 1'b1;
                end
                obs_req_cnt++;
            end
            #1;
            if (stall) obs_stall_cnt++;
            else begin
                obs_hung = 1'b0;
                break;
            end
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; dmem_ack = 1'b0;
        obs_req_after = dmem_req;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #3;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", stall); end
        total++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb} !== '0) begin bad++; $display("FAIL rst_bus: got req=%b addr=%h want all 0", dmem_req, dmem_addr); end
        total++; if ({wb_valid, wb_data, wb_rd, wb_reg_write} !== '0) begin bad++; $display("FAIL rst_wb: got v=%b d=%h want all 0", wb_valid, wb_data); end
        total++; if ({exc_misalign, exc_bus_err} !== 2'b00) begin bad++; $display("FAIL rst_exc: got %b%b want 00", exc_misalign, exc_bus_err); end
        #4 reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_nonmem();
        run_op(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'hDEAD_0000, 5'd5, 1'b1, 0, 32'h0);
        total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL nm_valid: got %b want 1", wb_valid); end
        total++; if (wb_data !== 32'h1234_5678) begin bad++; $display("FAIL nm_data: got %h want 12345678", wb_data); end
        total++; if ({wb_rd, wb_reg_write} !== {5'd5, 1'b1}) begin bad++; $display("FAIL nm_rd: got %0d/%b want 5/1", wb_rd, wb_reg_write); end
        total++; if (obs_stall_cnt !== 0 || obs_req_cnt !== 0) begin bad++; $display("FAIL nm_stall: got stall=%0d req=%0d want 0/0", obs_stall_cnt, obs_req_cnt); end
    endtask

    task automatic test_load_ext();
        run_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 2, 32'h80FF_FF00);
        total++; if (obs_stall_cnt !== 3) begin bad++; $display("FAIL lb_stall: got %0d want 3", obs_stall_cnt); end
        total++; if (wb_data !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_data: got %h want ffffff80", wb_data); end
        total++; if ({obs_addr, obs_we, obs_wstrb} !== {32'h100, 1'b0, 4'b0000}) begin bad++; $display("FAIL lb_bus: got addr=%h we=%b strb=%b want 100/0/0000", obs_addr, obs_we, obs_wstrb); end
        total++; if ({wb_valid, wb_reg_write, wb_rd} !== {1'b1, 1'b1, 5'd7}) begin bad++; $display("FAIL lb_wb: got v=%b rw=%b rd=%0d want 1/1/7", wb_valid, wb_reg_write, wb_rd); end
        run_op(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 2, 32'h80FF_FF00);
        total++; if (wb_data !== 32'h0000_0080) begin bad++; $display("FAIL lbu_data: got %h want 00000080", wb_data); end
    endtask

    task automatic test_store();
        run_op(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'hAAAA_BEEF, 5'd9, 1'b1, 0, 32'h0);
        total++; if (obs_addr !== 32'h200) begin bad++; $display("FAIL sh_addr: got %h want 200", obs_addr); end
        total++; if ({obs_we, obs_wstrb} !== 5'b1_1100) begin bad++; $display("FAIL sh_strb: got we=%b strb=%b want 1/1100", obs_we, obs_wstrb); end
        total++; if (obs_wdata !== 32'hBEEF_BEEF) begin bad++; $display("FAIL sh_wdata: got %h want beefbeef", obs_wdata); end
        total++; if ({wb_valid, wb_reg_write} !== 2'b10) begin bad++; $display("FAIL sh_wb: got v=%b rw=%b want 1/0", wb_valid, wb_reg_write); end
    endtask

    task automatic test_misalign();
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 5'd3, 1'b1, 0, 32'h0);
        total++; if (obs_req_cnt !== 0 || obs_stall_cnt !== 0) begin bad++; $display("FAIL mis_noreq: got req=%0d stall=%0d want 0/0", obs_req_cnt, obs_stall_cnt); end
        total++; if ({wb_valid, exc_misalign, wb_reg_write, exc_bus_err} !== 4'b1100) begin bad++; $display("FAIL mis_wb: got v=%b mis=%b rw=%b be=%b want 1/1/0/0", wb_valid, exc_misalign, wb_reg_write, exc_bus_err); end
    endtask

    task automatic test_timeout();
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd4, 1'b1, 99, 32'h0);
        total++; if (obs_req_cnt !== TO || obs_req_after !== 1'b0) begin bad++; $display("FAIL to_req: got cycles=%0d after=%b want %0d/0", obs_req_cnt, obs_req_after, TO); end
        total++; if ({wb_valid, exc_bus_err, wb_reg_write} !== 3'b110) begin bad++; $display("FAIL to_wb: got v=%b be=%b rw=%b want 1/1/0", wb_valid, exc_bus_err, wb_reg_write); end
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd4, 1'b1, TO - 1, 32'hCAFE_F00D);
        total++; if ({wb_valid, exc_bus_err, wb_reg_write} !== 3'b101) begin bad++; $display("FAIL to_ack_wb: got v=%b be=%b rw=%b want 1/0/1", wb_valid, exc_bus_err, wb_reg_write); end
        total++; if (wb_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL to_ack_data: got %h want cafef00d", wb_data); end
    endtask

    task automatic test_reset_mid_wait();
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
        alu_result = 32'h0000_0400; rd_in = 5'd11; reg_write_in = 1'b1; dmem_ack = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        total++; if ({dmem_req, stall} !== 2'b11) begin bad++; $display("FAIL mw_pre: got req=%b stall=%b want 1/1", dmem_req, stall); end
        #2 reset = 1'b0;
        #1;
        total++; if ({dmem_req, stall} !== 2'b00) begin bad++; $display("FAIL mw_drop: got req=%b stall=%b want 0/0", dmem_req, stall); end
        in_valid = 1'b0; mem_read = 1'b0;
        #2 reset = 1'b1;
        @(posedge clock); #1;
        total++; if ({dmem_req, wb_valid} !== 2'b00) begin bad++; $display("FAIL mw_idle: got req=%b v=%b want 0/0", dmem_req, wb_valid); end
        run_op(1'b1, 1'b0, 3'b101, 32'h0000_0402, 32'h0, 5'd12, 1'b1, 1, 32'h9876_5432);
        total++; if ({wb_valid, wb_data, wb_rd} !== {1'b1, 32'h0000_9876, 5'd12}) begin bad++; $display("FAIL mw_after: got v=%b d=%h rd=%0d want 1/00009876/12", wb_valid, wb_data, wb_rd); end
    endtask

    task automatic test_random();
        logic [2:0]  ld_f3s [6];
        logic [2:0]  f3;
        logic [31:0] addr, wd, rdata, exp_d;
        logic [4:0]  rd;
        logic        mr, mw, rw, is_mem, is_st, mis, ex_to, ex_rw;
        int          kind, sz, delay, ex_req, idles;
        ld_f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
        for (int n = 0; n < 120; n++) begin
            kind = $urandom_range(0, 2);
            mr = (kind == 1); mw = (kind == 2);
            if (kind == 1 && $urandom_range(0, 4) == 0) mw = 1'b1;
            f3 = mr ? ld_f3s[$urandom_range(0, 5)] : 3'($urandom_range(0, 2));
            sz = sz_of(f3);
            addr = $urandom();
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'(sz - 1);
            wd = $urandom(); rdata = $urandom(); rd = 5'($urandom()); rw = 1'($urandom());
            delay = $urandom_range(0, 5);
            if (delay >= TO) delay = 99;
            run_op(mr, mw, f3, addr, wd, rd, rw, delay, rdata);

            is_mem = mr | mw; is_st = mw & ~mr;
            mis    = is_mem && ((addr % sz) != 0);
            ex_to  = is_mem && !mis && delay >= TO;
            ex_req = (!is_mem || mis) ? 0 : ((delay < TO) ? delay + 1 : TO);
            ex_rw  = !is_mem ? rw : ((mis || ex_to || is_st) ? 1'b0 : rw);
            total++; if (obs_hung !== 1'b0 || wb_valid !== 1'b1) begin bad++; $display("FAIL rnd_valid[%0d]: got hung=%b v=%b want 0/1", n, obs_hung, wb_valid); end
            total++; if ({wb_rd, wb_reg_write, exc_misalign, exc_bus_err} !== {rd, ex_rw, mis, ex_to}) begin bad++; $display("FAIL rnd_ctl[%0d]: got rd=%0d rw=%b mis=%b be=%b want %0d/%b/%b/%b", n, wb_rd, wb_reg_write, exc_misalign, exc_bus_err, rd, ex_rw, mis, ex_to); end
            total++; if (obs_req_cnt !== ex_req || obs_stall_cnt !== ex_req || obs_req_after !== 1'b0) begin bad++; $display("FAIL rnd_timing[%0d]: got req=%0d stall=%0d after=%b want %0d/%0d/0", n, obs_req_cnt, obs_stall_cnt, obs_req_after, ex_req, ex_req); end
            if (!is_mem || (!mis && !ex_to && !is_st)) begin
                exp_d = is_mem ? m_load(f3, addr, rdata) : addr;
                total++; if (wb_data !== exp_d) begin bad++; $display("FAIL rnd_data[%0d]: f3=%b addr=%h got %h want %h", n, f3, addr, wb_data, exp_d); end
            end
            if (is_mem && !mis) begin
                total++; if ({obs_addr, obs_we, obs_bus_changed} !== {addr & ~32'h3, is_st, 1'b0}) begin bad++; $display("FAIL rnd_bus[%0d]: got addr=%h we=%b chg=%b want %h/%b/0", n, obs_addr, obs_we, obs_bus_changed, addr & ~32'h3, is_st); end
                if (is_st) begin
                    total++; if ({obs_wstrb, obs_wdata} !== {m_wstrb(sz, addr), m_wdata(sz, wd)}) begin bad++; $display("FAIL rnd_store[%0d]: got strb=%b wd=%h want %b/%h", n, obs_wstrb, obs_wdata, m_wstrb(sz, addr), m_wdata(sz, wd)); end
                end else begin
                    total++; if (obs_wstrb !== 4'b0000) begin bad++; $display("FAIL rnd_ldstrb[%0d]: got %b want 0000", n, obs_wstrb); end
                end
            end
            idles = $urandom_range(0, 2);
            for (int k = 0; k < idles; k++) begin
                dmem_ack = 1'($urandom());
                @(posedge clock); #1;
                total++; if ({wb_valid, dmem_req, wb_rd} !== {1'b0, 1'b0, rd}) begin bad++; $display("FAIL rnd_idle[%0d]: got v=%b req=%b rd=%0d want 0/0/%0d", n, wb_valid, dmem_req, wb_rd, rd); end
            end
            dmem_ack = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_load_ext();
        test_store();
        test_misalign();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
